// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES-128 key schedule and cipher core.
//   KEY_L / DATA_W : cipher-key and round-key widths (128 only)
//   IDX_W          : width of the round index
//   NR             : number of rounds for AES-128 (last round-key index)
//   RCON_INIT      : first round constant
//   state_t        : key-expansion FSM encoding
//   xtime()        : multiply by x in GF(2^8), reduction polynomial 0x11B
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int KEY_L  = 128;
    localparam int DATA_W = 128;
    localparam int IDX_W  = 4;

    localparam logic [IDX_W-1:0] NR        = 4'd10;
    localparam logic [7:0]       RCON_INIT = 8'h01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational FIPS-197 forward S-box (SubBytes on one byte).
//   din  : input byte
//   dout : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand.sv
// ---------------------------------------------------------------------------
// aes_key_expand
// Iterative AES-128 key schedule. Accepts a cipher key, then streams the 11
// round keys (index 0..10) one per handshake on a valid/ready interface.
//   clk, reset          : clock, synchronous active-high reset
//   key_valid/key_ready : cipher-key handshake (ready only while idle)
//   cipher_key          : key, [127:96] = w0
//   rk_valid/rk_ready   : round-key handshake toward the cipher core
//   rk_data, rk_idx     : current round key and its index
//   rk_last             : marks round key 10
//   busy                : expansion in progress
// ---------------------------------------------------------------------------
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_L  = 128,  // only 128 is supported
    parameter int DATA_W = 128   // equals KEY_L
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [KEY_L-1:0]  cipher_key,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [DATA_W-1:0] rk_data,
    output logic [IDX_W-1:0]  rk_idx,
    output logic              rk_last,
    output logic              busy
);

    state_t     state, state_next;
    logic [7:0] rcon;
    logic       load_key;
    logic       advance;

    // Round-key words, w0 in the most significant slot.
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3, sub_w3, temp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_data;

    // RotWord: cyclic left rotation by one byte.
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .din  (rot_w3[8*b +: 8]),
            .dout (sub_w3[8*b +: 8])
        );
    end

    assign temp = sub_w3 ^ {rcon, 24'h0};
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;

    // NOTE: every signal driven here gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load_key   = 1'b0;
        advance    = 1'b0;
        key_ready  = 1'b0;
        rk_valid   = 1'b0;
        busy       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    load_key   = 1'b1;
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                rk_valid = 1'b1;
                busy     = 1'b1;
                if (rk_ready) begin
                    // Key 10 consumed: drop back to idle, which inserts the
                    // one-cycle gap before the next key can be taken.
                    if (rk_idx == NR) state_next = ST_IDLE;
                    else              advance    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rk_last = rk_valid && (rk_idx == NR);

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: the round-key register is reset as well, because rk_data must
    // read as zero after reset rather than leak the previous key.
    always_ff @(posedge clk) begin
        if (reset) begin
            rk_data <= '0;
            rk_idx  <= '0;
            rcon    <= RCON_INIT;
        end else if (load_key) begin
            rk_data <= cipher_key;
            rk_idx  <= '0;
            rcon    <= RCON_INIT;
        end else if (advance) begin
            rk_data <= {n0, n1, n2, n3};
            rk_idx  <= rk_idx + IDX_W'(1);
            rcon    <= xtime(rcon);
        end
    end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have parameter KEY_L, default 128, cipher key width in bits; only 128 is supported.
REQ-002 SHALL have parameter DATA_W, default 128, round-key width in bits; it equals KEY_L.
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port key_valid, input, 1, cipher_key is valid this cycle.
REQ-006 SHALL have port key_ready, output, 1, block can accept a key this cycle.
REQ-007 SHALL have port cipher_key, input, KEY_L, cipher key; bits [127:96] = w0, MSB byte first.
REQ-008 SHALL have port rk_valid, output, 1, rk_data/rk_idx are valid.
REQ-009 SHALL have port rk_ready, input, 1, downstream cipher core accepts the round key.
REQ-010 SHALL have port rk_data, output, DATA_W, current round key {w4i, w4i+1, w4i+2, w4i+3}.
REQ-011 SHALL have port rk_idx, output, 4, round index 0..10 of rk_data.
REQ-012 SHALL have port rk_last, output, 1, high with rk_valid when rk_idx == 10.
REQ-013 SHALL have port busy, output, 1, high while a key expansion is in progress.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and EMIT.
REQ-015 In IDLE, SHALL drive key_ready = 1, rk_valid = 0 and busy = 0.
REQ-016 On key_valid && key_ready, SHALL load cipher_key as round key 0, set rk_idx = 0 and rcon = 8'h01, and enter EMIT.
REQ-017 SHALL assert rk_valid exactly 1 cycle after key acceptance, presenting round key 0 (the unmodified cipher key).
REQ-018 In EMIT, SHALL drive key_ready = 0 and busy = 1, and SHALL ignore key_valid.
REQ-019 While rk_valid && !rk_ready, SHALL hold rk_data, rk_idx and rk_last stable.
REQ-020 On rk_valid && rk_ready with rk_idx < 10, SHALL load the next round key, increment rk_idx and update rcon = xtime(rcon), all on the same edge; rk_valid stays 1.
REQ-021 The next-key rule SHALL be: temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}; w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-022 xtime SHALL be a left shift by 1, XORed with 8'h1B when bit 7 was set; the rcon sequence is 01,02,04,08,10,20,40,80,1B,36.
REQ-023 On rk_valid && rk_ready with rk_idx == 10, SHALL return to IDLE with rk_valid = 0 on the next cycle.
REQ-024 SHALL deassert key_ready for at least 1 cycle after the last handshake; a new key is accepted no earlier than the cycle after rk_valid falls.
REQ-025 The throughput limit SHALL be 11 round keys in 11 cycles with rk_ready held high; total latency from key accept to last handshake is 11 cycles.
REQ-026 rk_idx SHALL never exceed 10; no wrap to 11..15.

Reset
REQ-027 While reset is high at a clk edge, SHALL enter IDLE with key_ready = 1 on the following cycle.
REQ-028 While reset is high at a clk edge, SHALL clear rk_valid, rk_last, busy, rk_idx and rk_data to 0 and rcon to 8'h01.
REQ-029 Reset asserted mid-EMIT SHALL abort the expansion; no further round keys are issued for the aborted key.

Structure
REQ-030 The shared package aes_pkg SHALL hold: NR = 10, RCON_INIT = 8'h01, the FSM state encoding, and the width constants KEY_L, DATA_W and IDX_W = 4.
REQ-031 The combinational sub-module aes_sbox (8-bit in, 8-bit out, FIPS-197 table) SHALL be instantiated 4 times for SubWord; the same module is reused by the cipher core.

Verification
REQ-032 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready = 1 -> rk_idx 0 gives the key itself; rk_idx 1 gives a0fafe1788542cb123a339392a6c7605; rk_idx 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last = 1; 11 consecutive valid cycles.
REQ-033 Same key with rk_ready toggling 1,0,0,1,... -> rk_data and rk_idx stable during stalls; the same 11 keys appear in order; no skip or duplicate.
REQ-034 key_valid held high during EMIT with a different key -> key is ignored; the sequence matches the first key; the second key is accepted only after return to IDLE.
REQ-035 reset pulsed while rk_idx = 5 -> next cycle rk_valid = 0, key_ready = 1, rk_idx = 0; a fresh key 000...0 yields rk_idx 1 = 62636363626363636263636362636363.
REQ-036 Back-to-back keys with key_valid always high -> a one-cycle gap with rk_valid = 0 between the two sequences; both sequences correct.
